// File: rtl/apu_sfx_scheduler.sv
// Sound-effect scheduler: latches game-event requests, grants them by fixed
// priority and times each effect and the silent gap that follows it in video frames.
module apu_sfx_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int EFFECT_FRAMES = 24,
    parameter int GAP_FRAMES    = 2,
    parameter int PREEMPT       = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic [NUM_REQ-1:0] req,
    input  logic               bgm_enable,
    output logic               sfx_active,
    output logic [1:0]         sfx_code,
    output logic [4:0]         sfx_frame,
    output logic [NUM_REQ-1:0] req_ack,
    output logic [NUM_REQ-1:0] pending,
    output logic               bgm_on
);

    if (NUM_REQ < 1 || NUM_REQ > 4 || EFFECT_FRAMES < 1 || EFFECT_FRAMES > 32 ||
        GAP_FRAMES < 0 || GAP_FRAMES > 7 || PREEMPT < 0 || PREEMPT > 1) begin : g_param_err
        $error("apu_sfx_scheduler: parameter out of legal range");
    end

    localparam logic [4:0] FRAME_LAST = 5'(EFFECT_FRAMES - 1);
    localparam logic [2:0] GAP_LAST   = (GAP_FRAMES > 0) ? 3'(GAP_FRAMES - 1) : 3'd0;
    localparam bit         HAS_GAP    = (GAP_FRAMES > 0);
    localparam bit         CAN_PREEMPT = (PREEMPT != 0);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t             state;
    logic [2:0]         gap_cnt;
    logic [1:0]         winner;
    logic               any_pend;
    logic               preempt_hit;
    logic               do_grant;
    logic [NUM_REQ-1:0] grant_vec;

    // Lowest set index wins; scanning downward leaves the lowest one last.
    always_comb begin
        winner = 2'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending[i]) winner = 2'(i);
        end
    end

    assign any_pend    = |pending;
    assign preempt_hit = CAN_PREEMPT && (state == S_PLAY) && any_pend && (winner < sfx_code);
    assign do_grant    = ((state == S_IDLE) && any_pend) || preempt_hit;

    always_comb begin
        grant_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_vec[i] = do_grant && (winner == 2'(i));
        end
    end

    // A request arriving on its own grant edge is absorbed by that grant.
    always_ff @(posedge clk) begin
        if (!rst_n) pending <= '0;
        else        pending <= (pending | req) & ~grant_vec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sfx_active <= 1'b0;
            sfx_code   <= 2'd0;
            sfx_frame  <= 5'd0;
            req_ack    <= '0;
            gap_cnt    <= 3'd0;
            bgm_on     <= 1'b0;
        end else begin
            req_ack <= grant_vec;
            bgm_on  <= bgm_enable && (state == S_IDLE);
            if (do_grant) begin
                // Grant (or preemptive re-grant) always restarts the envelope.
                state      <= S_PLAY;
                sfx_active <= 1'b1;
                sfx_code   <= winner;
                sfx_frame  <= 5'd0;
            end else begin
                case (state)
                    S_PLAY: begin
                        if (frame_tick) begin
                            if (sfx_frame == FRAME_LAST) begin
                                sfx_active <= 1'b0;
                                sfx_frame  <= 5'd0;
                                gap_cnt    <= 3'd0;
                                state      <= HAS_GAP ? S_GAP : S_IDLE;
                            end else begin
                                sfx_frame <= sfx_frame + 5'd1;
                            end
                        end
                    end
                    S_GAP: begin
                        if (frame_tick) begin
                            if (gap_cnt == GAP_LAST) state <= S_IDLE;
                            else                     gap_cnt <= gap_cnt + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apu_sfx_scheduler.sv
// Bench for apu_sfx_scheduler: directed scenarios then random traffic, all
// checked every cycle against a frames-remaining reference model.
module tb_apu_sfx_scheduler;

    localparam int NR  = 4;
    localparam int EF  = 24;
    localparam int GF  = 2;
    localparam bit PRE = 1'b1;

    localparam int P_IDLE = 0;
    localparam int P_PLAY = 1;
    localparam int P_GAP  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_tick = 1'b0;
    logic [NR-1:0] req = '0;
    logic          bgm_enable = 1'b0;
    logic          sfx_active;
    logic [1:0]    sfx_code;
    logic [4:0]    sfx_frame;
    logic [NR-1:0] req_ack;
    logic [NR-1:0] pending;
    logic          bgm_on;

    always #5 clk = ~clk;

    apu_sfx_scheduler #(
        .NUM_REQ(NR), .EFFECT_FRAMES(EF), .GAP_FRAMES(GF), .PREEMPT(int'(PRE))
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .req(req),
        .bgm_enable(bgm_enable), .sfx_active(sfx_active), .sfx_code(sfx_code),
        .sfx_frame(sfx_frame), .req_ack(req_ack), .pending(pending), .bgm_on(bgm_on)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase, effect code, frames left to play, gap frames left.
    bit [NR-1:0] m_pend;
    bit [NR-1:0] m_ack;
    bit          m_bgm;
    int          m_phase, m_code, m_left, m_gap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input bit [NR-1:0] p);
        for (int i = 0; i < NR; i++) if (p[i]) return i;
        return -1;
    endfunction

    task automatic model_edge(input logic [NR-1:0] r, input logic t, input logic be, input logic rn);
        int w;
        bit g;
        if (!rn) begin
            m_pend = '0; m_ack = '0; m_bgm = 1'b0;
            m_phase = P_IDLE; m_code = 0; m_left = 0; m_gap = 0;
            return;
        end
        m_bgm = be && (m_phase == P_IDLE);
        w = lowest(m_pend);
        g = (w >= 0) && ((m_phase == P_IDLE) || (PRE && m_phase == P_PLAY && w < m_code));
        m_pend = m_pend | r;
        m_ack = '0;
        if (g) begin
            m_pend[w] = 1'b0;
            m_ack[w] = 1'b1;
            m_phase = P_PLAY; m_code = w; m_left = EF;
        end else if (m_phase == P_PLAY && t) begin
            m_left--;
            if (m_left == 0) begin
                if (GF > 0) begin m_phase = P_GAP; m_gap = GF; end
                else m_phase = P_IDLE;
            end
        end else if (m_phase == P_GAP && t) begin
            m_gap--;
            if (m_gap == 0) m_phase = P_IDLE;
        end
    endtask

    task automatic check_all();
        chk("active",  32'(sfx_active), 32'(m_phase == P_PLAY));
        chk("code",    32'(sfx_code),   32'(m_code));
        chk("frame",   32'(sfx_frame),  (m_phase == P_PLAY) ? 32'(EF - m_left) : 32'd0);
        chk("ack",     32'(req_ack),    32'(m_ack));
        chk("pending", 32'(pending),    32'(m_pend));
        chk("bgm",     32'(bgm_on),     32'(m_bgm));
    endtask

    task automatic step(input logic [NR-1:0] r, input logic t);
        req = r;
        frame_tick = t;
        model_edge(r, t, bgm_enable, rst_n);
        @(posedge clk);
        #1;
        req = '0;
        frame_tick = 1'b0;
        check_all();
    endtask

    task automatic tick_steps(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b1);
    endtask

    initial begin
        #1;
        // Reset
        rst_n = 1'b0;
        step('0, 1'b0);
        step('0, 1'b0);
        chk("rst_outs", 32'({sfx_active, sfx_code, sfx_frame, req_ack, pending, bgm_on}), 32'd0);

        // Idle with music, 100 frames, no requests
        rst_n = 1'b1;
        bgm_enable = 1'b1;
        step('0, 1'b0);
        chk("bgm_follow_on", 32'(bgm_on), 32'd1);
        for (int k = 0; k < 100; k++) begin
            step('0, 1'b1);
            step('0, 1'b0);
        end
        chk("idle_active", 32'(sfx_active), 32'd0);
        chk("idle_pending", 32'(pending), 32'd0);
        bgm_enable = 1'b0;
        step('0, 1'b0);
        chk("bgm_follow_off", 32'(bgm_on), 32'd0);
        bgm_enable = 1'b1;
        step('0, 1'b0);

        // Single request, full effect then gap
        step(4'b0100, 1'b0);
        chk("single_pend", 32'(pending), 32'h4);
        chk("single_notyet", 32'(sfx_active), 32'd0);
        step('0, 1'b0);
        chk("single_ack", 32'(req_ack), 32'h4);
        chk("single_code", 32'(sfx_code), 32'd2);
        chk("single_active", 32'(sfx_active), 32'd1);
        tick_steps(EF - 1);
        chk("single_lastframe", 32'(sfx_frame), 32'(EF - 1));
        tick_steps(1);
        chk("single_end", 32'(sfx_active), 32'd0);
        tick_steps(1);
        chk("gap_ducked", 32'(bgm_on), 32'd0);
        tick_steps(1);
        step('0, 1'b0);
        chk("gap_done_bgm", 32'(bgm_on), 32'd1);

        // Two simultaneous requests: priority order, second after effect + gap
        step(4'b1010, 1'b0);
        step('0, 1'b0);
        chk("pair_ack1", 32'(req_ack), 32'h2);
        chk("pair_code1", 32'(sfx_code), 32'd1);
        chk("pair_pend", 32'(pending), 32'h8);
        tick_steps(EF + GF);
        chk("pair_gapidle", 32'(sfx_active), 32'd0);
        step('0, 1'b0);
        chk("pair_ack3", 32'(req_ack), 32'h8);
        chk("pair_code3", 32'(sfx_code), 32'd3);

        // Preemption of code 3 at frame 5
        tick_steps(5);
        chk("pre_frame5", 32'(sfx_frame), 32'd5);
        step(4'b0001, 1'b0);
        step('0, 1'b0);
        chk("pre_code", 32'(sfx_code), 32'd0);
        chk("pre_frame", 32'(sfx_frame), 32'd0);
        chk("pre_ack", 32'(req_ack), 32'h1);
        chk("pre_nogap", 32'(sfx_active), 32'd1);
        tick_steps(EF + GF);

        // Coalescing and absorption of req[1]
        step(4'b0001, 1'b0);
        step('0, 1'b0);
        for (int k = 0; k < 5; k++) step(4'b0010, 1'b1);
        chk("coal_pend", 32'(pending), 32'h2);
        tick_steps(EF - 5 + GF);
        step(4'b0010, 1'b0);
        chk("coal_ack", 32'(req_ack), 32'h2);
        chk("coal_absorb", 32'(pending), 32'd0);
        tick_steps(EF + GF);
        for (int k = 0; k < 5; k++) step('0, 1'b0);
        chk("coal_once", 32'(sfx_active), 32'd0);
        chk("coal_clear", 32'(pending), 32'd0);

        // Reset in the middle of an effect with a request pending
        step(4'b1000, 1'b0);
        step('0, 1'b0);
        tick_steps(9);
        step(4'b1000, 1'b1);
        chk("mid_frame", 32'(sfx_frame), 32'd10);
        chk("mid_pend", 32'(pending), 32'h8);
        rst_n = 1'b0;
        step('0, 1'b0);
        chk("mid_rst", 32'({sfx_active, sfx_code, sfx_frame, req_ack, pending, bgm_on}), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step('0, 1'b1);
            step('0, 1'b0);
        end
        chk("mid_norestart", 32'(sfx_active), 32'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [NR-1:0] r;
            logic t;
            r = ($urandom_range(0, 9) == 0) ? NR'($urandom) : '0;
            t = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) bgm_enable = ~bgm_enable;
            rst_n = ($urandom_range(0, 399) != 0);
            step(r, t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
